// File: rtl/lvdt_osc_phase_ctrl.sv
// ---------------------------------------------------------------------------
// lvdt_osc_phase_ctrl
//   Multi-channel LVDT oscillator phase controller on an Avalon-MM slave.
//   Software writes per-channel phase targets into shadow registers, then
//   commits them all at once.  On commit, each live phase either jumps to
//   its target or ramps one LSB per tick along the shortest modulo path.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   reset      : asynchronous active-high reset
//   chipselect : Avalon slave select
//   address    : word address (SHADOW 0..NCH-1, CTRL NCH, STATUS NCH+1)
//   write_n    : active-low write strobe
//   read_n     : active-low read strobe
//   writedata  : 16-bit write data
//   readdata   : 16-bit registered read data, one cycle after the read
//   out_port   : live phases packed, channel k at [k*PW +: PW]
//   busy       : high while any live phase differs from its active target
// ---------------------------------------------------------------------------
module lvdt_osc_phase_ctrl #(
  parameter int NCH      = 4,
  parameter int PW       = 8,
  parameter int STEP_DIV = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic [NCH*PW-1:0] out_port,
  output logic              busy
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] HALF = {1'b1, {(PW-1){1'b0}}};

  state_t         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic           rampEn_q, rampEn_d;
  logic [PW-1:0]  shadow_q [NCH];
  logic [PW-1:0]  shadow_d [NCH];
  logic [PW-1:0]  target_q [NCH];
  logic [PW-1:0]  target_d [NCH];
  logic [PW-1:0]  live_q   [NCH];
  logic [PW-1:0]  live_d   [NCH];
  logic [15:0]    readdata_q, readdata_d;
  logic [PW-1:0]  stepDiff [NCH];

  logic wrEn, rdEn, ctrlSel, statusSel, commit, abort;
  logic unusedWdata;

  assign wrEn      = chipselect & ~write_n;
  assign rdEn      = chipselect & ~read_n;
  assign ctrlSel   = (address == ADDR_W'(NCH));
  assign statusSel = (address == ADDR_W'(NCH + 1));
  assign commit    = wrEn & ctrlSel & writedata[0];
  assign abort     = wrEn & ctrlSel & writedata[2];
  // Upper write-data bits are meaningless for narrow phase words.
  assign unusedWdata = ^writedata;

  assign readdata = readdata_q;

  // Pack live phases onto the output bus.
  always_comb begin
    out_port = '0;
    for (int k = 0; k < NCH; k++) out_port[k*PW +: PW] = live_q[k];
  end

  // Forward modulo distance from live to target; steers ramp direction.
  always_comb begin
    for (int k = 0; k < NCH; k++) stepDiff[k] = target_q[k] - live_q[k];
  end

  // busy: any channel still short of its target.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < NCH; k++)
      if (live_q[k] != target_q[k]) busy = 1'b1;
  end

  // Next-state logic: register file writes, FSM, ramp stepping, readback.
  // The RAMP_EN bit written with COMMIT decides jump vs ramp, since a CTRL
  // write always carries RAMP_EN. COMMIT takes precedence over ABORT.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    rampEn_d   = rampEn_q;
    shadow_d   = shadow_q;
    target_d   = target_q;
    live_d     = live_q;
    readdata_d = readdata_q;

    for (int k = 0; k < NCH; k++)
      if (wrEn && address == ADDR_W'(k)) shadow_d[k] = writedata[PW-1:0];
    if (wrEn && ctrlSel) rampEn_d = writedata[1];

    unique case (state_q)
      IDLE: begin
        if (commit) begin
          target_d = shadow_q;
          if (writedata[1]) begin
            tick_d  = '0;
            state_d = RAMP;
          end else begin
            live_d = shadow_q;
          end
        end
      end
      RAMP: begin
        if (commit) begin
          target_d = shadow_q;
          tick_d   = '0;
        end else if (abort) begin
          target_d = live_q;
          tick_d   = '0;
          state_d  = IDLE;
        end else if (!busy) begin
          tick_d  = '0;
          state_d = IDLE;
        end else if (tick_q == TW'(STEP_DIV - 1)) begin
          tick_d = '0;
          // An exact half-turn distance resolves upward.
          for (int k = 0; k < NCH; k++) begin
            if (stepDiff[k] != '0) begin
              if (stepDiff[k] <= HALF) live_d[k] = live_q[k] + PW'(1);
              else                     live_d[k] = live_q[k] - PW'(1);
            end
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rdEn) begin
      readdata_d = 16'h0000;
      for (int k = 0; k < NCH; k++)
        if (address == ADDR_W'(k)) readdata_d = 16'(live_q[k]);
      if (ctrlSel)   readdata_d = {14'b0, rampEn_q, 1'b0};
      if (statusSel) readdata_d = {8'(NCH), 7'b0, busy};
    end
  end

  // State register with asynchronous clear of all phases and controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      rampEn_q   <= 1'b0;
      readdata_q <= 16'h0000;
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= '0;
        target_q[k] <= '0;
        live_q[k]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      rampEn_q   <= rampEn_d;
      readdata_q <= readdata_d;
      shadow_q   <= shadow_d;
      target_q   <= target_d;
      live_q     <= live_d;
    end
  end

endmodule

// File: tb/tb_lvdt_osc_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lvdt_osc_phase_ctrl
//   Self-checking bench for lvdt_osc_phase_ctrl (NCH=4, PW=8, STEP_DIV=16).
//   Bus reads push their expected readdata into a queue that is popped when
//   the registered read data appears; phase and busy checks use cycle
//   offsets measured from each COMMIT edge.
// ---------------------------------------------------------------------------
module tb_lvdt_osc_phase_ctrl;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic [3:0]  address;
  logic        write_n;
  logic        read_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [31:0] out_port;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  int base = 0;
  logic [15:0] expQ [$];

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp;
  } rdVec_t;

  typedef struct {
    int         n;
    logic [7:0] ch0;
    logic       bsy;
  } rampVec_t;

  rdVec_t   resetVec [16];
  rdVec_t   jumpVec  [7];
  rampVec_t downVec  [8];

  lvdt_osc_phase_ctrl #(
    .NCH(4), .PW(8), .STEP_DIV(16), .ADDR_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .read_n    (read_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .busy      (busy)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used for ramp timing
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One bus cycle: idle edge, then the edge that captures the access.
  task automatic applyStimulus(input bit isWrite, input logic [3:0] addr,
                               input logic [15:0] data);
    @(negedge clk);
    chipselect = 1'b1;
    address    = addr;
    writedata  = data;
    write_n    = ~isWrite;
    read_n     = isWrite;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  task automatic busRead(input string name, input logic [3:0] addr,
                         input logic [15:0] exp);
    logic [15:0] e;
    expQ.push_back(exp);
    applyStimulus(1'b0, addr, 16'h0000);
    if (expQ.size() == 0) begin
      checkOutput({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput(name, {16'h0, readdata}, {16'h0, e});
    end
  endtask

  task automatic commitNow(input logic [15:0] ctrl);
    applyStimulus(1'b1, 4'd4, ctrl);
    base = cyc;
  endtask

  // Bounded: cyc advances every clock, so this always terminates.
  task automatic waitTo(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  initial begin
    chipselect = 1'b0;
    address    = '0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = '0;
    reset      = 1'b1;

    for (int i = 0; i < 16; i++) begin
      resetVec[i].addr = 4'(i);
      resetVec[i].exp  = (i == 5) ? 16'h0400 : 16'h0000;
    end
    jumpVec[0] = '{4'd0, 16'h0040};
    jumpVec[1] = '{4'd1, 16'h0000};
    jumpVec[2] = '{4'd2, 16'h00C0};
    jumpVec[3] = '{4'd3, 16'h0000};
    jumpVec[4] = '{4'd4, 16'h0000};
    jumpVec[5] = '{4'd5, 16'h0400};
    jumpVec[6] = '{4'd9, 16'h0000};
    downVec[0] = '{15, 8'h02, 1'b1};
    downVec[1] = '{16, 8'h01, 1'b1};
    downVec[2] = '{31, 8'h01, 1'b1};
    downVec[3] = '{32, 8'h00, 1'b1};
    downVec[4] = '{47, 8'h00, 1'b1};
    downVec[5] = '{48, 8'hFF, 1'b1};
    downVec[6] = '{63, 8'hFF, 1'b1};
    downVec[7] = '{64, 8'hFE, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_out_port", out_port, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_readdata", {16'h0, readdata}, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++)
      busRead($sformatf("rst_rd%0d", i), resetVec[i].addr, resetVec[i].exp);

    // Immediate jump with RAMP_EN=0
    applyStimulus(1'b1, 4'd4, 16'h0000);
    applyStimulus(1'b1, 4'd0, 16'h0040);
    applyStimulus(1'b1, 4'd2, 16'h00C0);
    applyStimulus(1'b1, 4'd9, 16'hFFFF);
    checkOutput("jump_before_commit", out_port, 32'h0);
    commitNow(16'h0001);
    checkOutput("jump_out_port", out_port, 32'h00C00040);
    checkOutput("jump_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 7; i++)
      busRead($sformatf("jump_rd%0d", i), jumpVec[i].addr, jumpVec[i].exp);

    // Downward ramp through zero: 0x02 -> 0xFE
    applyStimulus(1'b1, 4'd0, 16'h0002);
    commitNow(16'h0001);
    checkOutput("down_start", out_port, 32'h00C00002);
    applyStimulus(1'b1, 4'd4, 16'h0002);
    busRead("ctrl_rampen", 4'd4, 16'h0002);
    applyStimulus(1'b1, 4'd0, 16'h00FE);
    commitNow(16'h0003);
    checkOutput("down_busy_rise", {31'h0, busy}, 32'h1);
    busRead("down_status_busy", 4'd5, 16'h0401);
    for (int i = 0; i < 8; i++) begin
      waitTo(downVec[i].n);
      checkOutput($sformatf("down_ch0_n%0d", downVec[i].n),
                  {24'h0, out_port[7:0]}, {24'h0, downVec[i].ch0});
      checkOutput($sformatf("down_busy_n%0d", downVec[i].n),
                  {31'h0, busy}, {31'h0, downVec[i].bsy});
    end
    checkOutput("down_final_word", out_port, 32'h00C000FE);
    busRead("down_status_idle", 4'd5, 16'h0400);

    // Half-turn tie: 0x00 -> 0x80 resolves upward, 128 steps
    applyStimulus(1'b1, 4'd0, 16'h0000);
    commitNow(16'h0001);
    applyStimulus(1'b1, 4'd0, 16'h0080);
    commitNow(16'h0003);
    waitTo(15);
    checkOutput("tie_n15", {24'h0, out_port[7:0]}, 32'h00);
    waitTo(16);
    checkOutput("tie_first_step", {24'h0, out_port[7:0]}, 32'h01);
    waitTo(2047);
    checkOutput("tie_n2047", {24'h0, out_port[7:0]}, 32'h7F);
    checkOutput("tie_busy_n2047", {31'h0, busy}, 32'h1);
    waitTo(2048);
    checkOutput("tie_done", {24'h0, out_port[7:0]}, 32'h80);
    checkOutput("tie_busy_done", {31'h0, busy}, 32'h0);

    // Mid-ramp COMMIT reverses without a jump, then ABORT freezes
    applyStimulus(1'b1, 4'd0, 16'h0090);
    commitNow(16'h0003);
    waitTo(56);
    checkOutput("rev_pre", {24'h0, out_port[7:0]}, 32'h83);
    applyStimulus(1'b1, 4'd0, 16'h0070);
    commitNow(16'h0003);
    checkOutput("rev_no_jump", {24'h0, out_port[7:0]}, 32'h83);
    checkOutput("rev_busy", {31'h0, busy}, 32'h1);
    waitTo(15);
    checkOutput("rev_n15", {24'h0, out_port[7:0]}, 32'h83);
    waitTo(16);
    checkOutput("rev_step_down", {24'h0, out_port[7:0]}, 32'h82);
    applyStimulus(1'b1, 4'd4, 16'h0006);
    checkOutput("abort_busy", {31'h0, busy}, 32'h0);
    checkOutput("abort_ch0", {24'h0, out_port[7:0]}, 32'h82);
    repeat (40) @(negedge clk);
    checkOutput("abort_frozen", out_port, 32'h00C00082);
    busRead("abort_status", 4'd5, 16'h0400);

    // Mid-ramp reset pulse
    applyStimulus(1'b1, 4'd0, 16'h0010);
    commitNow(16'h0003);
    waitTo(20);
    checkOutput("rst_mid_pre", {24'h0, out_port[7:0]}, 32'h81);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_out", out_port, 32'h0);
    checkOutput("rst_mid_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_hold_out", out_port, 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("rst_after_out", out_port, 32'h0);
    checkOutput("rst_after_busy", {31'h0, busy}, 32'h0);
    busRead("rst_after_ctrl", 4'd4, 16'h0000);

    // ABORT while IDLE changes nothing
    applyStimulus(1'b1, 4'd0, 16'h0033);
    commitNow(16'h0001);
    applyStimulus(1'b1, 4'd4, 16'h0004);
    checkOutput("idle_abort_out", out_port, 32'h00000033);
    checkOutput("idle_abort_busy", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
